gauss_filter: RTL
=================

Name: gauss_filter

Overview:
- Downstream consumer of the 6x6 pixel window buffer.
- When the window is complete, the upstream controller pulses `start`. The block then captures the window and computes a 3x3 Gaussian blur (kernel 1 2 1 / 2 4 2 / 1 2 1, divided by 16) over every valid 3x3 position.
- Output is 4x4 = 16 filtered pixels, streamed one per handshake, with a done pulse at the end.
- Output feeds the edge/gradient stage.

Parameters:
- PIXEL_W, 8, bits per pixel.
- WIN_DIM, 6, window edge length.
- K_DIM, 3, kernel edge length (fixed at 3; kernel weights are constants).
- OUT_DIM, WIN_DIM-K_DIM+1 = 4, output grid edge length (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- window_in  in  [5:0][5:0][7:0]  pixel window, indexed [x][y].
- out_ready  in  1  downstream accepts pixel_out this cycle.
- busy  out  1  high in CALC and DRAIN.
- out_valid  out  1  pixel_out/out_x/out_y hold a valid result.
- pixel_out  out  8  filtered pixel.
- out_x  out  2  output column 0..3.
- out_y  out  2  output row 0..3.
- done  out  1  one-cycle pulse after the final pixel is accepted.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy, out_valid, done, pixel_out, out_x, out_y = 0.
  - Internal window register and index counters = 0.
  - Asserting rst mid-run aborts immediately. No done pulse is produced.
- States: IDLE, CALC, DRAIN, DONE.
- IDLE:
  - On start=1 at edge N, copy window_in into the internal window register and clear the index to (x=0, y=0).
  - Go to CALC.
  - start=0 keeps the block in IDLE.
- CALC:
  - Load slot is free when out_valid=0 or (out_valid & out_ready).
  - When the slot is free, register the result for the current (x,y) into pixel_out/out_x/out_y, set out_valid=1, and advance the index.
  - Index order is x-major: x increments 0..3, then wraps to 0 and y increments.
  - Loading index (3,3) moves to DRAIN.
  - First out_valid is asserted after edge N+1, one cycle after start was sampled.
- DRAIN: on out_valid & out_ready, clear out_valid and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- With out_ready held high:
  - 16 back-to-back valid cycles.
  - done is asserted the cycle after the 16th handshake.
- Output register:
  - Holds pixel_out/out_x/out_y stable while out_valid=1 and out_ready=0.
  - No result is skipped or duplicated.
- Arithmetic:
  - sum = Σ(i,j in 0..2) w[x+i][y+j]·k[i][j], computed at 12-bit width (max 4080).
  - pixel_out = (sum + 8) >> 4, round-half-up. The maximum is 255, so no saturation logic is needed.
- start while busy or in DONE is ignored.
- Changes to window_in after capture do not affect results.
- Simultaneous out_ready acceptance and a new load in the same cycle is legal in CALC: the old result retires and the new one loads.

Decomposition:
- Package gauss_pkg:
  - PIXEL_W, WIN_DIM, K_DIM, OUT_DIM constants.
  - Kernel weight constant array.
  - Window typedef [WIN_DIM-1:0][WIN_DIM-1:0][PIXEL_W-1:0].
  - State enum {IDLE, CALC, DRAIN, DONE}.
- Sub-module gauss_kernel3: purely combinational.
  - Input: 3x3 pixel patch.
  - Output: rounded 8-bit weighted average.
- gauss_filter holds the FSM, window register, index counters and output register.

Test Plan:
1. Reset: assert rst during CALC after 5 outputs -> all outputs 0 immediately; no done; a new start afterwards yields a full 16-pixel run from (0,0).
2. Uniform window, all 0x80, out_ready=1 -> exactly 16 outputs of 0x80 in order (0,0),(1,0)…(3,3); done pulses one cycle after the last; busy falls with done.
3. Impulse window, window_in[2][2]=0xFF, rest 0:
   - (0,0)=0x10, (1,0)=0x20, (1,1)=0x40, (2,2)=0x10, (3,3)=0x00.
   - (0,1)=0x20, (2,1)=0x20.
4. Backpressure: drop out_ready for 5 cycles after the first valid -> (0,0) output stable for 5 cycles, then the sequence continues with no gap in indices; 16 handshakes total.
5. Ignore/capture: pulse start again mid-run and change window_in to all 0xFF after capture -> run unaffected (values per original window), single done.
6. Saturation bound: all-0xFF window -> all 16 outputs 0xFF; all-0x00 window -> all 0x00.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian blur over the 6x6 pixel window.
package gauss_pkg;
    localparam int PIXEL_W = 8;
    localparam int WIN_DIM = 6;
    localparam int K_DIM   = 3;
    localparam int OUT_DIM = WIN_DIM - K_DIM + 1;
    localparam int SUM_W   = 12;

    typedef logic [K_DIM-1:0][K_DIM-1:0][2:0] kernel_t;

    // 1 2 1 / 2 4 2 / 1 2 1 -- symmetric, so index order does not matter.
    localparam kernel_t KERNEL = {3'd1, 3'd2, 3'd1,
                                  3'd2, 3'd4, 3'd2,
                                  3'd1, 3'd2, 3'd1};

    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][PIXEL_W-1:0] window_t;
    typedef logic [K_DIM-1:0][K_DIM-1:0][PIXEL_W-1:0]     patch_t;

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_e;
endpackage

// File: rtl/gauss_kernel3.sv
// Combinational 3x3 Gaussian: weighted sum of a patch, divided by 16 with round-half-up.
module gauss_kernel3
    import gauss_pkg::*;
(
    input  logic [K_DIM-1:0][K_DIM-1:0][PIXEL_W-1:0] patch_i,
    output logic [PIXEL_W-1:0]                       pixel_o
);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rounded;

    // Weights total 16, so the worst-case sum is 4080 and (sum + 8) still fits 12 bits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < K_DIM; i++) begin
            for (int j = 0; j < K_DIM; j++) begin
                sum = sum + SUM_W'(patch_i[i][j]) * SUM_W'(KERNEL[i][j]);
            end
        end
        rounded = sum + SUM_W'(8);
        pixel_o = rounded[SUM_W-1:4];
    end
endmodule

// File: rtl/gauss_filter.sv
// Captures a 6x6 window on start and streams the 4x4 blurred result, one pixel per handshake.
module gauss_filter
    import gauss_pkg::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [WIN_DIM-1:0][WIN_DIM-1:0][PIXEL_W-1:0] window_in,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic                                         out_valid,
    output logic [PIXEL_W-1:0]                           pixel_out,
    output logic [1:0]                                   out_x,
    output logic [1:0]                                   out_y,
    output logic                                         done
);
    localparam logic [1:0] LAST_IDX = 2'(OUT_DIM - 1);

    state_e         state_q, state_d;
    window_t        win_q, win_d;
    logic [1:0]     x_q, x_d, y_q, y_d;
    logic           valid_q, valid_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic [1:0]     ox_q, ox_d, oy_q, oy_d;

    patch_t         patch;
    logic [PIXEL_W-1:0] kern_pix;
    logic           slot_free;

    always_comb begin
        for (int i = 0; i < K_DIM; i++) begin
            for (int j = 0; j < K_DIM; j++) begin
                patch[i][j] = win_q[{1'b0, x_q} + 3'(i)][{1'b0, y_q} + 3'(j)];
            end
        end
    end

    gauss_kernel3 u_kernel (
        .patch_i (patch),
        .pixel_o (kern_pix)
    );

    // The output register may take a new result when empty or retiring this cycle.
    assign slot_free = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        pix_d   = pix_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d   = window_in;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    pix_d   = kern_pix;
                    ox_d    = x_q;
                    oy_d    = y_q;
                    if (x_q == LAST_IDX) begin
                        x_d = '0;
                        y_d = y_q + 2'd1;
                    end else begin
                        x_d = x_q + 2'd1;
                    end
                    if (x_q == LAST_IDX && y_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            pix_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    assign busy      = (state_q == CALC) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign out_valid = valid_q;
    assign pixel_out = pix_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
endmodule
